// File: rtl/alu_pkg.sv
// Shared constants for the ALU command issuer: function codes, flag
// bit positions and issuer FSM encoding.
package alu_pkg;

  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_MUL  = 4'h2;
  localparam logic [3:0] FN_DIV  = 4'h3;
  localparam logic [3:0] FN_AND  = 4'h4;
  localparam logic [3:0] FN_OR   = 4'h5;
  localparam logic [3:0] FN_NAND = 4'h6;
  localparam logic [3:0] FN_NOR  = 4'h7;
  localparam logic [3:0] FN_XOR  = 4'h8;
  localparam logic [3:0] FN_XNOR = 4'h9;
  localparam logic [3:0] FN_EQ   = 4'hA;
  localparam logic [3:0] FN_GT   = 4'hB;
  localparam logic [3:0] FN_LT   = 4'hC;
  localparam logic [3:0] FN_SHR  = 4'hD;
  localparam logic [3:0] FN_SHL  = 4'hE;
  localparam logic [3:0] FN_NOP  = 4'hF;

  localparam int FL_CARRY = 0;
  localparam int FL_ARITH = 1;
  localparam int FL_LOGIC = 2;
  localparam int FL_CMP   = 3;
  localparam int FL_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with count-based full/empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time and returns results
// in order. Define ALU_FWD_EN to forward the last result into operand A.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FUN_W-1:0]  cmd_fun,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_FWD_EN
  input  logic              cmd_fwd,
`endif
  output logic [FUN_W-1:0]  alu_fun,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_flags,
  output logic              busy
);

`ifdef ALU_FWD_EN
  localparam int EW = FUN_W + 2*DATA_W + 1;
`else
  localparam int EW = FUN_W + 2*DATA_W;
`endif
  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0]    LAT_C = CW'(ALU_LAT);
  localparam logic [FUN_W-1:0] NOP   = FUN_W'(FN_NOP);

  logic [EW-1:0]     push_ent;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              load;
  logic              hd_fwd;
  logic [FUN_W-1:0]  hd_fun;
  logic [DATA_W-1:0] hd_a;
  logic [DATA_W-1:0] hd_b;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [4:0]        rf_q, rf_d;

`ifdef ALU_FWD_EN
  assign push_ent = {cmd_fwd, cmd_fun, cmd_a, cmd_b};
  assign hd_fwd   = head[EW-1];
`else
  assign push_ent = {cmd_fun, cmd_a, cmd_b};
  assign hd_fwd   = 1'b0;
`endif
  assign hd_fun = head[2*DATA_W +: FUN_W];
  assign hd_a   = head[DATA_W +: DATA_W];
  assign hd_b   = head[0 +: DATA_W];

  alu_cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (cmd_valid),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fun_d   = fun_q;
    a_d     = a_q;
    b_d     = b_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rf_d    = rf_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        fun_d = NOP;
        load  = !empty;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rd_d    = alu_out;
          rf_d    = alu_flags;
          rv_d    = 1'b1;
          fun_d   = NOP;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          load    = !empty;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // rd_q doubles as the forwarding register: it holds the last capture
    if (load) begin
      pop     = 1'b1;
      fun_d   = hd_fun;
      a_d     = hd_fwd ? rd_q : hd_a;
      b_d     = hd_b;
      cnt_d   = LAT_C;
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fun_q   <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rf_q    <= rf_d;
    end
  end

  assign cmd_ready = !full;
  assign alu_fun   = fun_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign rsp_flags = rf_q;
  assign busy      = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 1-cycle ALU and
// an in-order scoreboard of expected responses.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int LAT = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_fun = 4'h0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_fwd = 1'b0;
  logic [3:0]  alu_fun;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out = '0;
  logic [4:0]  alu_flags = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic        busy;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  f;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_res = '0;
  int          checks = 0;
  int          errors = 0;

  alu_cmd_issuer dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_fun   (cmd_fun),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
`ifdef ALU_FWD_EN
    .cmd_fwd   (cmd_fwd),
`endif
    .alu_fun   (alu_fun),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [20:0] alu_f(input logic [3:0] f,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic [4:0]  fl;
    w  = '0;
    r  = '0;
    fl = '0;
    case (f)
      FN_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0]; fl[FL_ARITH] = 1'b1; fl[FL_CARRY] = w[16];
      end
      FN_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0]; fl[FL_ARITH] = 1'b1; fl[FL_CARRY] = w[16];
      end
      FN_MUL:  begin r = a * b; fl[FL_ARITH] = 1'b1; end
      FN_DIV:  begin r = (b == 0) ? 16'h0 : a / b; fl[FL_ARITH] = 1'b1; end
      FN_AND:  begin r = a & b;    fl[FL_LOGIC] = 1'b1; end
      FN_OR:   begin r = a | b;    fl[FL_LOGIC] = 1'b1; end
      FN_NAND: begin r = ~(a & b); fl[FL_LOGIC] = 1'b1; end
      FN_NOR:  begin r = ~(a | b); fl[FL_LOGIC] = 1'b1; end
      FN_XOR:  begin r = a ^ b;    fl[FL_LOGIC] = 1'b1; end
      FN_XNOR: begin r = ~(a ^ b); fl[FL_LOGIC] = 1'b1; end
      FN_EQ:   begin r = {15'h0, a == b}; fl[FL_CMP] = 1'b1; end
      FN_GT:   begin r = {15'h0, a > b};  fl[FL_CMP] = 1'b1; end
      FN_LT:   begin r = {15'h0, a < b};  fl[FL_CMP] = 1'b1; end
      FN_SHR:  begin r = a >> b[3:0]; fl[FL_SHIFT] = 1'b1; end
      FN_SHL:  begin r = a << b[3:0]; fl[FL_SHIFT] = 1'b1; end
      default: begin r = '0; fl = '0; end
    endcase
    return {fl, r};
  endfunction

  always @(posedge CLK) {alu_flags, alu_out} <= alu_f(alu_fun, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_spurious_valid", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.d));
        check("rsp_flags", 32'(rsp_flags), 32'(e.f));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [3:0] f, input logic [15:0] a,
                      input logic [15:0] b, input logic fw);
    int          n;
    logic [15:0] ea;
    logic [20:0] r;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_fun   = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_fwd   = fw;
    ea        = a;
`ifdef ALU_FWD_EN
    if (fw) ea = last_res;
`endif
    r = alu_f(f, ea, b);
    sb.push_back('{r[15:0], r[20:16]});
    last_res = r[15:0];
    step();
    cmd_valid = 1'b0;
    cmd_fwd   = 1'b0;
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_fun", 32'(alu_fun), 32'hF);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    RST = 1'b0;
    step();

    // Single ADD and its issue latency.
    rsp_ready = 1'b1;
    send(FN_ADD, 16'd1, 16'd1, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("latency_edges", 32'(n), 32'(LAT + 2));
    check("add_data", 32'(rsp_data), 32'h0002);
    check("add_flags", 32'(rsp_flags), 32'b00010);
    wait_drain();
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Fill under backpressure, hold, then drain in order.
    rsp_ready = 1'b0;
    send(FN_SUB, 16'd5, 16'd3, 1'b0);
    send(FN_DIV, 16'd6, 16'd3, 1'b0);
    send(FN_XOR, 16'd1, 16'd1, 1'b0);
    send(FN_XNOR, 16'd1, 16'd1, 1'b0);
    send(FN_EQ, 16'd1, 16'd1, 1'b0);
    check("full_not_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_fun   = FN_ADD;
    cmd_a     = 16'd7;
    cmd_b     = 16'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_stays", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    wait_rsp_valid();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'h0002);
      check("hold_flags", 32'(rsp_flags), 32'b00010);
      check("hold_alu_fun", 32'(alu_fun), 32'hF);
      step();
    end
    rsp_ready = 1'b1;
    wait_drain();
    step();
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_ready", 32'(cmd_ready), 32'd1);

    // Reset while a command is in WAIT and another is queued.
    send(FN_ADD, 16'd2, 16'd2, 1'b0);
    send(FN_MUL, 16'd3, 16'd3, 1'b0);
    RST       = 1'b1;
    cmd_valid = 1'b1;
    cmd_fun   = FN_ADD;
    cmd_a     = 16'd9;
    cmd_b     = 16'd9;
    step();
    cmd_valid = 1'b0;
    sb.delete();
    last_res = '0;
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_alu_fun", 32'(alu_fun), 32'hF);
    check("rstw_alu_a", 32'(alu_a), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("flush_no_rsp", 32'(rsp_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
    end

    // Simultaneous push and pop with DEPTH-1 entries queued.
    rsp_ready = 1'b0;
    send(FN_AND, 16'h00FF, 16'h0F0F, 1'b0);
    send(FN_OR, 16'h00F0, 16'h0F00, 1'b0);
    send(FN_GT, 16'd9, 16'd4, 1'b0);
    send(FN_SHL, 16'h0001, 16'd4, 1'b0);
    wait_rsp_valid();
    rsp_ready = 1'b1;
    send(FN_SHR, 16'h8000, 16'd15, 1'b0);
    rsp_ready = 1'b0;
    check("pushpop_ready", 32'(cmd_ready), 32'd1);
    send(FN_NOR, 16'h0000, 16'h00FF, 1'b0);
    check("pushpop_full", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    wait_drain();

    // NOP passes through, then the forwarding pair.
    send(FN_NOP, 16'h1234, 16'h5678, 1'b0);
    send(FN_LT, 16'd2, 16'd3, 1'b0);
    send(FN_ADD, 16'd1, 16'd1, 1'b0);
    send(FN_ADD, 16'd1, 16'd3, 1'b1);
    wait_drain();
    step();
    step();
    check("end_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
